// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer:
// ALU control codes for the HI/LO class and the FSM state encoding.
package muldiv_sequencer_pkg;

   localparam logic [4:0] OPMULT  = 5'h18;
   localparam logic [4:0] OPMULTU = 5'h19;
   localparam logic [4:0] OPDIV   = 5'h1A;
   localparam logic [4:0] OPDIVU  = 5'h1B;
   localparam logic [4:0] OPMTHI  = 5'h1C;
   localparam logic [4:0] OPMTLO  = 5'h1D;
   localparam logic [4:0] OPMFHI  = 5'h1E;
   localparam logic [4:0] OPMFLO  = 5'h1F;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_e;

   // Any of the eight codes this block answers to
   function automatic logic is_hilo_op(input logic [4:0] op);
      return (op == OPMULT) || (op == OPMULTU) || (op == OPDIV)  || (op == OPDIVU) ||
             (op == OPMTHI) || (op == OPMTLO)  || (op == OPMFHI) || (op == OPMFLO);
   endfunction

   // Codes that start an iterative (or fast) multiply/divide
   function automatic logic is_muldiv_op(input logic [4:0] op);
      return (op == OPMULT) || (op == OPMULTU) || (op == OPDIV) || (op == OPDIVU);
   endfunction

endpackage

// File: rtl/muldiv_sequencer_step.sv
// One iteration of the shift-add multiplier or the restoring divider.
// Multiply: {acc,q} holds the partial product with the multiplier in q;
//   acc += b when q[0], then the pair shifts right by one.
// Divide: {acc,q} holds remainder/dividend; shift left one bit, try to
//   subtract b from the widened remainder, keep it and shift in 1 if it fits.
module muldiv_step #(
   parameter int WIDTH = 32
) (
   input  logic             div_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic [WIDTH-1:0] b_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] q_o
);

   logic [WIDTH:0] sum;
   logic [WIDTH:0] trial;
   logic [WIDTH:0] diff;

   // Both candidate results are formed every cycle; mode picks one.
   // The remainder stays below b, so trial fits in WIDTH+1 bits and the
   // top bit of diff is a clean borrow flag.
   always_comb begin
      sum   = {1'b0, acc_i} + (q_i[0] ? {1'b0, b_i} : {(WIDTH+1){1'b0}});
      trial = {acc_i, q_i[WIDTH-1]};
      diff  = trial - {1'b0, b_i};
      if (div_i) begin
         if (!diff[WIDTH]) begin
            acc_o = diff[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = trial[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b0};
         end
      end else begin
         acc_o = sum[WIDTH:1];
         q_o   = {sum[0], q_i[WIDTH-1:1]};
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// HI/LO sequencer for MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO.
// Owns HI/LO, runs WIDTH iterations of muldiv_step for multiply/divide and
// stalls HI/LO-class requests while an operation is in flight.
// Optional feature macro: MULDIV_FAST_MULT_EN -- multiplies are done with a
// single combinational product in the accept cycle (IDLE->FIX).
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input  logic             iCLK,
   input  logic             iRST,
   input  logic             iStart,
   input  logic [4:0]       iOp,
   input  logic [WIDTH-1:0] iA,
   input  logic [WIDTH-1:0] iB,
   output logic             oStall,
   output logic             oBusy,
   output logic             oDone,
   output logic [WIDTH-1:0] oHI,
   output logic [WIDTH-1:0] oLO
);
   import muldiv_sequencer_pkg::*;

   state_e           state_q;
   logic [CNT_W-1:0] count_q;
   logic [WIDTH-1:0] hi_q, lo_q;
   logic [WIDTH-1:0] acc_q, q_q, b_q;
   logic             div_q;
   logic             neg_p_q;   // negate product / quotient
   logic             neg_r_q;   // negate remainder
   logic             done_q;

   logic             op_div, op_signed, a_neg, b_neg, b_zero;
   logic [WIDTH-1:0] mag_a, mag_b;
   logic [WIDTH-1:0] step_acc_d, step_q_d;
   logic [WIDTH-1:0] hi_d, lo_d;
   logic [2*WIDTH-1:0] prod_d;

   // Operand decode: sign flags and magnitudes (raw for unsigned ops)
   always_comb begin
      op_div    = (iOp == OPDIV) || (iOp == OPDIVU);
      op_signed = (iOp == OPDIV) || (iOp == OPMULT);
      a_neg     = op_signed & iA[WIDTH-1];
      b_neg     = op_signed & iB[WIDTH-1];
      mag_a     = a_neg ? -iA : iA;
      mag_b     = b_neg ? -iB : iB;
      b_zero    = (iB == '0);
   end

`ifdef MULDIV_FAST_MULT_EN
   logic [2*WIDTH-1:0] fast_prod;
   assign fast_prod = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`endif

   muldiv_step #(.WIDTH(WIDTH)) u_step (
      .div_i (div_q),
      .acc_i (acc_q),
      .q_i   (q_q),
      .b_i   (b_q),
      .acc_o (step_acc_d),
      .q_o   (step_q_d)
   );

   // Sign fix-up applied to the unsigned result when leaving FIX
   always_comb begin
      prod_d = neg_p_q ? -{acc_q, q_q} : {acc_q, q_q};
      if (div_q) begin
         hi_d = neg_r_q ? -acc_q : acc_q;
         lo_d = neg_p_q ? -q_q   : q_q;
      end else begin
         hi_d = prod_d[2*WIDTH-1:WIDTH];
         lo_d = prod_d[WIDTH-1:0];
      end
   end

   // Main FSM: accept, iterate, fix signs and write HI/LO
   always_ff @(posedge iCLK or posedge iRST) begin
      if (iRST) begin
         state_q <= IDLE;
         count_q <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         b_q     <= '0;
         div_q   <= 1'b0;
         neg_p_q <= 1'b0;
         neg_r_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (iStart) begin
                  if (is_muldiv_op(iOp)) begin
                     div_q   <= op_div;
                     neg_p_q <= a_neg ^ b_neg;
                     neg_r_q <= a_neg;
                     acc_q   <= '0;
                     if (op_div && b_zero) begin
                        // divide by zero: HI=dividend, LO=all ones, no iterations
                        acc_q   <= iA;
                        q_q     <= '1;
                        neg_p_q <= 1'b0;
                        neg_r_q <= 1'b0;
                        state_q <= FIX;
                     end
`ifdef MULDIV_FAST_MULT_EN
                     else if (!op_div) begin
                        {acc_q, q_q} <= fast_prod;
                        state_q      <= FIX;
                     end
`endif
                     else begin
                        q_q     <= op_div ? mag_a : mag_b;
                        b_q     <= op_div ? mag_b : mag_a;
                        count_q <= CNT_W'(WIDTH);
                        state_q <= RUN;
                     end
                  end else if (iOp == OPMTHI) begin
                     hi_q <= iA;
                  end else if (iOp == OPMTLO) begin
                     lo_q <= iA;
                  end
               end
            end
            RUN: begin
               acc_q   <= step_acc_d;
               q_q     <= step_q_d;
               count_q <= count_q - 1'b1;
               if (count_q == CNT_W'(1)) state_q <= FIX;
            end
            FIX: begin
               hi_q    <= hi_d;
               lo_q    <= lo_d;
               done_q  <= 1'b1;
               state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign oStall = iStart & is_hilo_op(iOp) & (state_q != IDLE);
   assign oBusy  = (state_q == RUN) || (state_q == FIX);
   assign oDone  = done_q;
   assign oHI    = hi_q;
   assign oLO    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed vector table, hand
// sequences for stall/reset corners and random ops against an arithmetic model.
module tb_muldiv_sequencer;
   import muldiv_sequencer_pkg::*;

`ifdef MULDIV_FAST_MULT_EN
   localparam int MUL_LAT = 2;
`else
   localparam int MUL_LAT = 34;
`endif
   localparam int DIV_LAT = 34;

   logic        iCLK = 1'b0;
   logic        iRST = 1'b1;
   logic        iStart = 1'b0;
   logic [4:0]  iOp = 5'd0;
   logic [31:0] iA = '0, iB = '0;
   logic        oStall, oBusy, oDone;
   logic [31:0] oHI, oLO;

   int checks = 0;
   int failures = 0;

   muldiv_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
      .iCLK(iCLK), .iRST(iRST), .iStart(iStart), .iOp(iOp), .iA(iA), .iB(iB),
      .oStall(oStall), .oBusy(oBusy), .oDone(oDone), .oHI(oHI), .oLO(oLO)
   );

   always #5 iCLK = ~iCLK;

   typedef struct {
      logic [4:0]  op;
      logic [31:0] a, b, hi, lo;
      int          lat;
   } vec_t;

   vec_t tbl[10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   // Reference: plain 64-bit arithmetic; returns {HI,LO}
   function automatic logic [63:0] ref_model(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
      longint      sa, sb, q, m;
      logic [63:0] r, qq, mm;
      sa = $signed(a);
      sb = $signed(b);
      r  = '0;
      if (op == OPMULT) r = sa * sb;
      else if (op == OPMULTU) r = {32'd0, a} * {32'd0, b};
      else if (b == 32'd0) r = {a, 32'hFFFFFFFF};
      else if (op == OPDIV) begin
         q  = sa / sb;
         m  = sa % sb;
         qq = q;
         mm = m;
         r  = {mm[31:0], qq[31:0]};
      end else r = {a % b, a / b};
      return r;
   endfunction

   // Present an op at a negedge, then count edges (accept edge = 1) until oDone
   task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy, output logic stall0);
      @(negedge iCLK);
      iStart = 1'b1; iOp = op; iA = a; iB = b;
      #1 stall0 = oStall;
      @(posedge iCLK); #1;
      iStart = 1'b0;
      lat = 1; busy = 0;
      while (!oDone && lat < 200) begin
         if (oBusy) busy++;
         @(posedge iCLK); #1;
         lat++;
      end
   endtask

   initial begin
      int          lat, busy, n, stalls, dones, exp_lat;
      logic        st0;
      logic [4:0]  op;
      logic [31:0] a, b;
      logic [4:0]  md_ops[4];
      md_ops = '{OPMULT, OPMULTU, OPDIV, OPDIVU};

      tbl[0] = '{OPMULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, MUL_LAT};
      tbl[1] = '{OPDIVU,  32'd100,      32'd7,        32'd2,        32'd14,       DIV_LAT};
      tbl[2] = '{OPDIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, DIV_LAT};
      tbl[3] = '{OPDIV,   32'h00001234, 32'd0,        32'h00001234, 32'hFFFFFFFF, 2};
      tbl[4] = '{OPDIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, DIV_LAT};
      tbl[5] = '{OPMULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, MUL_LAT};
      tbl[6] = '{OPMULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MUL_LAT};
      tbl[7] = '{OPDIVU,  32'd5,        32'd10,       32'd5,        32'd0,        DIV_LAT};
      tbl[8] = '{OPDIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, DIV_LAT};
      tbl[9] = '{OPDIVU,  32'hFFFFFFFF, 32'd1,        32'd0,        32'hFFFFFFFF, DIV_LAT};

      // reset state
      repeat (2) @(posedge iCLK);
      @(negedge iCLK) iRST = 1'b0;
      #1;
      chk("rst_hi", 64'(oHI), 64'd0);
      chk("rst_lo", 64'(oLO), 64'd0);
      chk("rst_busy_done_stall", {61'd0, oBusy, oDone, oStall}, 64'd0);

      // MTLO / MTHI
      @(negedge iCLK); iStart = 1'b1; iOp = OPMTLO; iA = 32'hCAFE;
      #1 chk("mtlo_stall", 64'(oStall), 64'd0);
      @(posedge iCLK); #1; iOp = OPMTHI; iA = 32'hBEEF;
      chk("mtlo_lo", 64'(oLO), 64'hCAFE);
      chk("mtlo_done", 64'(oDone), 64'd0);
      @(posedge iCLK); #1; iStart = 1'b0;
      chk("mthi_hi", 64'(oHI), 64'hBEEF);

      // non HI/LO op with iStart is ignored
      @(negedge iCLK); iStart = 1'b1; iOp = 5'd3; iA = 32'h1111; iB = 32'h0;
      #1 chk("ign_stall", 64'(oStall), 64'd0);
      @(posedge iCLK); #1; iStart = 1'b0;
      chk("ign_hilo", {oHI, oLO}, {32'hBEEF, 32'hCAFE});
      chk("ign_busy", 64'(oBusy), 64'd0);

      // directed table
      for (int i = 0; i < 10; i++) begin
         do_op(tbl[i].op, tbl[i].a, tbl[i].b, lat, busy, st0);
         chk($sformatf("tbl%0d_stall", i), 64'(st0), 64'd0);
         chk($sformatf("tbl%0d_hilo", i), {oHI, oLO}, {tbl[i].hi, tbl[i].lo});
         chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'(tbl[i].lat));
         chk($sformatf("tbl%0d_busy", i), 64'(busy), 64'(tbl[i].lat - 1));
      end

      // new op presented in the FIX cycle is stalled, then taken after
      @(negedge iCLK); iStart = 1'b1; iOp = OPDIV; iA = 32'd5; iB = 32'd0;
      @(posedge iCLK); #1; iOp = OPMULTU; iA = 32'd3; iB = 32'd4;
      #1 chk("fix_stall", 64'(oStall), 64'd1);
      @(posedge iCLK); #1;
      chk("fix_done_stall", {62'd0, oDone, oStall}, 64'd2);
      @(posedge iCLK); #1; iStart = 1'b0;
      n = 1;
      while (!oDone && n < 200) begin @(posedge iCLK); #1; n++; end
      chk("fix_mult_lat", 64'(n), 64'(MUL_LAT));
      chk("fix_mult_hilo", {oHI, oLO}, 64'd12);

      // MFHI behind an unfinished divide stalls until the oDone cycle
      @(negedge iCLK); iStart = 1'b1; iOp = OPDIVU; iA = 32'd100; iB = 32'd7;
      @(posedge iCLK); #1; iStart = 1'b0;
      repeat (4) @(posedge iCLK);
      @(negedge iCLK); iStart = 1'b1; iOp = OPMFHI;
      #1;
      stalls = 0; n = 0;
      while (!oDone && n < 100) begin
         if (oStall) stalls++;
         @(negedge iCLK); #1;
         n++;
      end
      chk("mfhi_stall_cycles", 64'(stalls), 64'd29);
      chk("mfhi_done_stall", {62'd0, oDone, oStall}, 64'd2);
      chk("mfhi_hi", 64'(oHI), 64'd2);
      @(posedge iCLK); #1; iStart = 1'b0;
      chk("mfhi_idle", {62'd0, oBusy, oDone}, 64'd0);

      // random ops against the model; back-to-back issue lands in the oDone cycle
      for (int i = 0; i < 40; i++) begin
         op = md_ops[$urandom_range(0, 3)];
         a  = $urandom;
         b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
         if ($urandom_range(0, 9) == 0) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
         if ($urandom_range(0, 4) == 0) b = b >> $urandom_range(16, 31);
         do_op(op, a, b, lat, busy, st0);
         if (op == OPMULT || op == OPMULTU) exp_lat = MUL_LAT;
         else exp_lat = (b == 32'd0) ? 2 : DIV_LAT;
         chk($sformatf("rnd%0d_op%0h_a%h_b%h", i, op, a, b), {oHI, oLO}, ref_model(op, a, b));
         chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(exp_lat));
      end

      // reset in the middle of RUN (count=10) discards the op
      @(negedge iCLK); iStart = 1'b1; iOp = OPDIVU; iA = 32'd1000; iB = 32'd3;
      @(posedge iCLK); #1; iStart = 1'b0;
      repeat (22) @(posedge iCLK);
      @(negedge iCLK); iRST = 1'b1;
      #1;
      chk("rrun_hilo", {oHI, oLO}, 64'd0);
      chk("rrun_busy_done", {62'd0, oBusy, oDone}, 64'd0);
      @(negedge iCLK); iRST = 1'b0;
      dones = 0;
      repeat (40) begin
         @(posedge iCLK); #1;
         if (oDone || oBusy) dones++;
      end
      chk("rrun_no_done", 64'(dones), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
